// File: rtl/updown_count_scheduler.sv
// updown_count_scheduler
// Two requesters (A, B) share one embedded up/down counter. A winner is chosen
// round-robin. Its start/end operands are captured and the counter is loaded
// with the start value. The counter then steps toward the end value once every
// DWELL cycles, and a done pulse goes to the owner when the end value is reached.
//
// Handshake (req/gnt): req_x is a level request, and its operands must stay
// stable while it is high. gnt_x is a one-cycle pulse in the cycle after the
// accepting edge, and the requester drops req_x in the cycle after it sees
// gnt_x. A request that is still high when the block is idle counts as a new
// request. A request raised while the block is busy waits until the block is
// idle again and is not lost while it stays high.
module updown_count_scheduler #(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] start_a,
  input  logic [WIDTH-1:0] end_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] start_b,
  input  logic [WIDTH-1:0] end_b,
  input  logic             abort,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic [1:0]       state_dbg
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic             mode_nx;
  logic             gnt_a_nx, gnt_b_nx, done_a_nx, done_b_nx;
  logic             owner_b, owner_b_nx;   // 1 = run belongs to B
  logic [WIDTH-1:0] cap_start, cap_start_nx;
  logic [WIDTH-1:0] cap_end, cap_end_nx;
  logic             rr_b, rr_b_nx;         // 1 = B preferred on a tie
  logic [DW-1:0]    dwell, dwell_nx;
  logic             win_b;
  logic [WIDTH-1:0] q_step;

  assign state_dbg = state;

  // Next-state and next-output logic. Abort takes priority over load, step and completion.
  always_comb begin
    state_nx     = state;
    q_nx         = Q;
    mode_nx      = mode;
    gnt_a_nx     = 1'b0;
    gnt_b_nx     = 1'b0;
    done_a_nx    = 1'b0;
    done_b_nx    = 1'b0;
    owner_b_nx   = owner_b;
    cap_start_nx = cap_start;
    cap_end_nx   = cap_end;
    rr_b_nx      = rr_b;
    dwell_nx     = dwell;
    win_b        = req_b && (!req_a || rr_b);
    q_step       = mode ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));

    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          owner_b_nx   = win_b;
          cap_start_nx = win_b ? start_b : start_a;
          cap_end_nx   = win_b ? end_b : end_a;
          gnt_a_nx     = !win_b;
          gnt_b_nx     = win_b;
          rr_b_nx      = !win_b;
          state_nx     = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          q_nx     = cap_start;
          mode_nx  = (cap_end >= cap_start);
          dwell_nx = '0;
          if (cap_start == cap_end) begin
            state_nx  = DONE;
            done_a_nx = !owner_b;
            done_b_nx = owner_b;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          q_nx     = q_step;
          if (q_step == cap_end) begin
            state_nx  = DONE;
            done_a_nx = !owner_b;
            done_b_nx = owner_b;
          end
        end else begin
          dwell_nx = dwell + DW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset wins over everything, including mid-run.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      Q         <= '0;
      mode      <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      busy      <= 1'b0;
      owner_b   <= 1'b0;
      cap_start <= '0;
      cap_end   <= '0;
      rr_b      <= 1'b0;
      dwell     <= '0;
    end else begin
      state     <= state_nx;
      Q         <= q_nx;
      mode      <= mode_nx;
      gnt_a     <= gnt_a_nx;
      gnt_b     <= gnt_b_nx;
      done_a    <= done_a_nx;
      done_b    <= done_b_nx;
      busy      <= (state_nx != IDLE);
      owner_b   <= owner_b_nx;
      cap_start <= cap_start_nx;
      cap_end   <= cap_end_nx;
      rr_b      <= rr_b_nx;
      dwell     <= dwell_nx;
    end
  end

endmodule
